// File: rtl/sel_adder_nch.sv
// Selectable-channel adder: a select token picks one of NCH A inputs, which is added
// to either a B operand or the previous result (accumulate), with optional saturation.
module sel_adder_nch #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SAT   = 0,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  input  logic [SELW:0]        sel_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [WIDTH-1:0]     b_data,
  input  logic [NCH-1:0]       a_valid,
  output logic [NCH-1:0]       a_ready,
  input  logic [NCH*WIDTH-1:0] a_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_ovf,
  output logic                 out_err
);

  typedef enum logic [1:0] {LOAD, GETA, SEND} state_t;

  localparam logic [SELW:0] NCH_LIM = NCH[SELW:0];

  state_t            state_reg, state_next;
  logic              sel_held_reg, acc_flag_reg, b_held_reg;
  logic [SELW-1:0]   idx_reg;
  logic [WIDTH-1:0]  b_reg, opb_reg, acc_reg, out_data_reg;
  logic              out_ovf_reg, out_err_reg;

  logic              sel_fire, b_fire, a_fire, out_fire;
  logic              acc_now, known_acc, idx_bad, load_done;
  logic [SELW-1:0]   idx_now;
  logic [WIDTH-1:0]  a_arr [NCH];
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH:0]    sum;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign a_arr[gi]   = a_data[gi*WIDTH +: WIDTH];
      assign a_ready[gi] = (state_reg == GETA) && (idx_reg == SELW'(gi));
    end
  endgenerate

  // Token fields come from the held copy once captured, otherwise from the incoming token.
  assign acc_now   = sel_held_reg ? acc_flag_reg : sel_data[SELW];
  assign idx_now   = sel_held_reg ? idx_reg : sel_data[SELW-1:0];
  assign known_acc = sel_held_reg ? acc_flag_reg : (sel_valid && sel_data[SELW]);
  assign idx_bad   = {1'b0, idx_now} >= NCH_LIM;

  assign sel_fire  = sel_valid && sel_ready;
  assign b_fire    = b_valid && b_ready;
  assign a_fire    = |(a_valid & a_ready);
  assign out_fire  = out_valid && out_ready;
  assign load_done = (sel_held_reg || sel_fire) && (acc_now || b_held_reg || b_fire);

  assign a_sel = a_arr[idx_reg];
  assign sum   = {1'b0, a_sel} + {1'b0, opb_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (load_done) state_next = idx_bad ? SEND : GETA;
      GETA:    if (a_fire) state_next = SEND;
      SEND:    if (out_fire) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // B is never accepted once the pending token is known to accumulate.
  always_comb begin
    sel_ready = 1'b0;
    b_ready   = 1'b0;
    if (state_reg == LOAD && !rst) begin
      sel_ready = !sel_held_reg;
      b_ready   = !b_held_reg && !known_acc;
    end
    out_valid = (state_reg == SEND);
    out_data  = out_data_reg;
    out_ovf   = out_ovf_reg;
    out_err   = out_err_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_held_reg <= 1'b0;
      acc_flag_reg <= 1'b0;
      b_held_reg   <= 1'b0;
      idx_reg      <= '0;
      b_reg        <= '0;
      opb_reg      <= '0;
      acc_reg      <= '0;
      out_data_reg <= '0;
      out_ovf_reg  <= 1'b0;
      out_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (sel_fire) begin
            acc_flag_reg <= sel_data[SELW];
            idx_reg      <= sel_data[SELW-1:0];
          end
          if (b_fire) b_reg <= b_data;
          sel_held_reg <= (sel_held_reg || sel_fire) && !load_done;
          // A B captured ahead of an accumulate token is kept for the next token.
          b_held_reg   <= (b_held_reg || b_fire) && !(load_done && !acc_now);
          if (load_done) begin
            opb_reg      <= acc_now ? acc_reg : (b_held_reg ? b_reg : b_data);
            out_err_reg  <= idx_bad;
            out_data_reg <= '0;
            out_ovf_reg  <= 1'b0;
          end
        end
        GETA: begin
          if (a_fire) begin
            out_data_reg <= (SAT != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            out_ovf_reg  <= sum[WIDTH];
            out_err_reg  <= 1'b0;
          end
        end
        SEND: begin
          if (out_fire && !out_err_reg) acc_reg <= out_data_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sel_adder_nch.sv
// Bench for sel_adder_nch: directed table, hand-written corner sequences and a randomized
// run against a stream-level model, on a wrap/NCH=4 instance and a saturating/NCH=3 instance.
module tb_sel_adder_nch;

  localparam int NT = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel_valid [2];
  logic [2:0]  sel_data  [2];
  logic        sel_ready [2];
  logic        b_valid   [2];
  logic [7:0]  b_data    [2];
  logic        b_ready   [2];
  logic [3:0]  a_valid   [2];
  logic [31:0] a_data    [2];
  logic [3:0]  a_ready_w [2];
  logic [3:0]  a_ready0;
  logic [2:0]  a_ready1;
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  out_data  [2];
  logic        out_ovf   [2];
  logic        out_err   [2];

  assign a_ready_w[0] = a_ready0;
  assign a_ready_w[1] = {1'b0, a_ready1};

  sel_adder_nch #(.WIDTH(8), .NCH(4), .SAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid[0]), .sel_ready(sel_ready[0]), .sel_data(sel_data[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_data(b_data[0]),
    .a_valid(a_valid[0]), .a_ready(a_ready0), .a_data(a_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_ovf(out_ovf[0]), .out_err(out_err[0])
  );

  sel_adder_nch #(.WIDTH(8), .NCH(3), .SAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid[1]), .sel_ready(sel_ready[1]), .sel_data(sel_data[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_data(b_data[1]),
    .a_valid(a_valid[1][2:0]), .a_ready(a_ready1), .a_data(a_data[1][23:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_ovf(out_ovf[1]), .out_err(out_err[1])
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int d);
    sel_valid[d] = 1'b0; sel_data[d] = '0;
    b_valid[d]   = 1'b0; b_data[d]   = '0;
    a_valid[d]   = '0;   a_data[d]   = '0;
    out_ready[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(0); idle(1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction with all channels' A valid; flags protocol violations.
  task automatic run_txn(input int d, input bit acc, input int idx, input logic [7:0] b,
                         input logic [7:0] a, output logic [7:0] od, output logic oo,
                         output logic oe, output int proto_bad);
    int  a_cyc;
    bit  done, sf, bf, af;
    proto_bad = 0; a_cyc = -1; done = 1'b0; od = '0; oo = 1'b0; oe = 1'b0;
    sel_valid[d] = 1'b1; sel_data[d] = {acc, 2'(idx)};
    b_valid[d]   = 1'b1; b_data[d]   = b;
    out_ready[d] = 1'b1;
    a_valid[d]   = 4'hF; a_data[d] = 32'hA3B7C1D9;
    a_data[d][idx*8 +: 8] = a;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      #1;
      if (acc && b_ready[d]) proto_bad++;
      if ((a_ready_w[d] & ~(4'b0001 << idx)) != 4'b0000) proto_bad++;
      if (out_valid[d]) begin
        od = out_data[d]; oo = out_ovf[d]; oe = out_err[d]; done = 1'b1;
        if (!out_err[d] && a_cyc != cyc - 1) proto_bad++;
        if (out_err[d] && a_cyc != -1) proto_bad++;
      end
      sf = sel_valid[d] && sel_ready[d];
      bf = b_valid[d] && b_ready[d];
      af = |(a_valid[d] & a_ready_w[d]);
      if (af) a_cyc = cyc;
      @(posedge clk); @(negedge clk);
      if (sf) sel_valid[d] = 1'b0;
      if (bf) b_valid[d] = 1'b0;
      if (af) a_valid[d] = '0;
    end
    idle(d);
    if (!done) proto_bad += 100;
  endtask

  typedef struct {
    int         d;
    bit         acc;
    int         idx;
    logic [7:0] b;
    logic [7:0] a;
    logic [7:0] ed;
    bit         eo;
    bit         ee;
  } vec_t;

  vec_t tbl [9];

  // Randomized-run model state
  bit         t_acc [2][NT];
  int         t_idx [2][NT];
  logic [7:0] t_a   [2][NT];
  logic [7:0] bq    [2][NT];
  logic [7:0] e_data[2][NT];
  bit         e_ovf [2][NT];
  bit         e_err [2][NT];
  int         nb [2], sp [2], bp [2], oc [2];

  initial begin
    logic [7:0] od;
    logic       oo, oe;
    int         pb, n_out, stable_bad, ready_bad;

    tbl[0] = '{0, 1'b0, 2, 8'h10, 8'h05, 8'h15, 1'b0, 1'b0};
    tbl[1] = '{0, 1'b0, 1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    tbl[2] = '{1, 1'b0, 1, 8'hF0, 8'h20, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{0, 1'b0, 2, 8'h10, 8'h05, 8'h15, 1'b0, 1'b0};
    tbl[4] = '{0, 1'b1, 0, 8'h99, 8'h03, 8'h18, 1'b0, 1'b0};
    tbl[5] = '{1, 1'b0, 3, 8'h01, 8'h55, 8'h00, 1'b0, 1'b1};
    tbl[6] = '{1, 1'b1, 0, 8'h99, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{0, 1'b1, 3, 8'h99, 8'hE8, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{1, 1'b1, 2, 8'h99, 8'h01, 8'hFF, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    idle(0); idle(1);
    repeat (3) @(negedge clk);
    #1;
    check("rst_sel_ready", sel_ready[0], 0);
    check("rst_b_ready", b_ready[0], 0);
    check("rst_a_ready", a_ready_w[0], 0);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_out_data", out_data[0], 0);
    check("rst_out_ovf", out_ovf[0], 0);
    check("rst_out_err", out_err[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_sel_ready", sel_ready[0], 1);
    check("post_rst_b_ready", b_ready[0], 1);
    check("post_rst_b_ready_1", b_ready[1], 1);
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].d, tbl[i].acc, tbl[i].idx, tbl[i].b, tbl[i].a, od, oo, oe, pb);
      $display("txn %0d: dut%0d acc=%0d idx=%0d b=%02h a=%02h -> data=%02h ovf=%0d err=%0d",
               i, tbl[i].d, tbl[i].acc, tbl[i].idx, tbl[i].b, tbl[i].a, od, oo, oe);
      check($sformatf("tbl%0d_data", i), od, tbl[i].ed);
      check($sformatf("tbl%0d_ovf", i), oo, tbl[i].eo);
      check($sformatf("tbl%0d_err", i), oe, tbl[i].ee);
      check($sformatf("tbl%0d_proto", i), pb, 0);
    end

    // Back-pressure: B three cycles ahead of sel, then output stalled for five cycles
    n_out = 0; stable_bad = 0; ready_bad = 0;
    b_valid[0] = 1'b1; b_data[0] = 8'h33;
    #1;
    check("bp_b_ready_first", b_ready[0], 1);
    @(posedge clk); @(negedge clk);
    b_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    check("bp_b_held_off", b_ready[0], 0);
    @(posedge clk); @(negedge clk);
    sel_valid[0] = 1'b1; sel_data[0] = 3'b001;
    a_valid[0] = 4'b0010; a_data[0] = 32'h00004400;
    @(posedge clk); @(negedge clk);
    sel_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    a_valid[0] = '0;
    b_valid[0] = 1'b1; b_data[0] = 8'h01;
    sel_valid[0] = 1'b1; sel_data[0] = 3'b000;
    a_valid[0] = 4'b0001; a_data[0] = 32'h00000002;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (!out_valid[0] || out_data[0] != 8'h77) stable_bad++;
      if (sel_ready[0] || b_ready[0] || a_ready_w[0] != 4'b0000) ready_bad++;
      if (out_valid[0] && out_ready[0]) n_out++;
      @(posedge clk); @(negedge clk);
    end
    check("bp_out_stable", stable_bad, 0);
    check("bp_ready_in_send", ready_bad, 0);
    out_ready[0] = 1'b1;
    #1;
    check("bp_out_data", out_data[0], 8'h77);
    if (out_valid[0] && out_ready[0]) n_out++;
    @(posedge clk); @(negedge clk);
    out_ready[0] = 1'b0;
    #1;
    if (out_valid[0]) n_out++;
    check("bp_next_sel_ready", sel_ready[0], 1);
    check("bp_next_b_ready", b_ready[0], 1);
    @(posedge clk); @(negedge clk);
    sel_valid[0] = 1'b0; b_valid[0] = 1'b0;
    #1;
    check("bp_next_a_ready", a_ready_w[0], 4'b0001);
    @(posedge clk); @(negedge clk);
    a_valid[0] = '0; out_ready[0] = 1'b1;
    #1;
    check("bp_next_out_valid", out_valid[0], 1);
    check("bp_next_out_data", out_data[0], 8'h03);
    check("bp_one_transfer", n_out, 1);
    @(posedge clk); @(negedge clk);
    idle(0);
    $display("txn bp: b=33 a[1]=44 -> 77 stalled 5 cycles, then b=01 a[0]=02 -> 03");

    // Reset while a result is pending in SEND
    sel_valid[0] = 1'b1; sel_data[0] = 3'b010; b_valid[0] = 1'b1; b_data[0] = 8'h10;
    a_valid[0] = 4'b0100; a_data[0] = 32'h00050000;
    @(posedge clk); @(negedge clk);
    sel_valid[0] = 1'b0; b_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    a_valid[0] = '0;
    #1;
    check("mid_rst_in_send", out_valid[0], 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_async_valid", out_valid[0], 0);
    check("mid_rst_async_data", out_data[0], 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_sel_ready", sel_ready[0], 1);
    @(negedge clk);
    run_txn(0, 1'b1, 2, 8'h99, 8'h07, od, oo, oe, pb);
    $display("txn mid_rst: acc a[2]=07 -> data=%02h ovf=%0d err=%0d", od, oo, oe);
    check("mid_rst_acc_data", od, 8'h07);
    check("mid_rst_acc_ovf", oo, 0);
    check("mid_rst_proto", pb, 0);

    // Randomized run against the stream model
    do_reset();
    for (int d = 0; d < 2; d++) begin
      int         nch, s;
      logic [7:0] accv, opb;
      nch = (d == 0) ? 4 : 3;
      accv = '0; nb[d] = 0; sp[d] = 0; bp[d] = 0; oc[d] = 0;
      for (int t = 0; t < NT; t++) begin
        t_acc[d][t] = ($urandom % 3) == 0;
        t_idx[d][t] = $urandom % 4;
        t_a[d][t]   = 8'($urandom);
        if (t_acc[d][t]) opb = accv;
        else begin
          opb = 8'($urandom);
          bq[d][nb[d]] = opb;
          nb[d]++;
        end
        if (t_idx[d][t] >= nch) begin
          e_data[d][t] = '0; e_ovf[d][t] = 1'b0; e_err[d][t] = 1'b1;
        end else begin
          s = int'(t_a[d][t]) + int'(opb);
          e_ovf[d][t]  = s > 255;
          e_err[d][t]  = 1'b0;
          e_data[d][t] = (s > 255 && d == 1) ? 8'hFF : 8'(s % 256);
          accv = e_data[d][t];
        end
      end
    end
    begin
      bit         sf [2], bf [2], prev_hold [2];
      logic [7:0] prev_data [2];
      int         stray, hold_bad, cyc;
      stray = 0; hold_bad = 0; cyc = 0;
      sf = '{0, 0}; bf = '{0, 0}; prev_hold = '{0, 0}; prev_data = '{0, 0};
      while ((oc[0] < NT || oc[1] < NT) && cyc < 3000) begin
        for (int d = 0; d < 2; d++) begin
          if (sf[d]) sel_valid[d] = 1'b0;
          if (bf[d]) b_valid[d] = 1'b0;
          if (!sel_valid[d] && sp[d] < NT && ($urandom % 2) == 0) begin
            sel_valid[d] = 1'b1;
            sel_data[d]  = {t_acc[d][sp[d]], 2'(t_idx[d][sp[d]])};
          end
          if (!b_valid[d] && bp[d] < nb[d] && ($urandom % 2) == 0) begin
            b_valid[d] = 1'b1;
            b_data[d]  = bq[d][bp[d]];
          end
          a_valid[d] = 4'($urandom);
          a_data[d]  = $urandom;
          if (oc[d] < NT) a_data[d][t_idx[d][oc[d]]*8 +: 8] = t_a[d][oc[d]];
          out_ready[d] = ($urandom % 3) != 0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
          sf[d] = sel_valid[d] && sel_ready[d];
          bf[d] = b_valid[d] && b_ready[d];
          if (oc[d] < NT && (a_ready_w[d] & ~(4'b0001 << t_idx[d][oc[d]])) != 4'b0000) stray++;
          if (prev_hold[d] && (!out_valid[d] || out_data[d] != prev_data[d])) hold_bad++;
          prev_hold[d] = out_valid[d] && !out_ready[d];
          prev_data[d] = out_data[d];
          if (out_valid[d] && out_ready[d]) begin
            if (oc[d] < NT) begin
              $display("rnd dut%0d #%0d: acc=%0d idx=%0d a=%02h -> data=%02h ovf=%0d err=%0d",
                       d, oc[d], t_acc[d][oc[d]], t_idx[d][oc[d]], t_a[d][oc[d]],
                       out_data[d], out_ovf[d], out_err[d]);
              check($sformatf("rnd%0d_%0d_data", d, oc[d]), out_data[d], e_data[d][oc[d]]);
              check($sformatf("rnd%0d_%0d_ovf", d, oc[d]), out_ovf[d], e_ovf[d][oc[d]]);
              check($sformatf("rnd%0d_%0d_err", d, oc[d]), out_err[d], e_err[d][oc[d]]);
              oc[d]++;
            end else begin
              check($sformatf("rnd%0d_extra_out", d), 1, 0);
            end
          end
          if (sf[d]) sp[d]++;
          if (bf[d]) bp[d]++;
        end
        @(posedge clk); @(negedge clk);
        cyc++;
      end
      check("rnd0_all_done", oc[0], NT);
      check("rnd1_all_done", oc[1], NT);
      check("rnd_stray_a_ready", stray, 0);
      check("rnd_out_hold", hold_bad, 0);
      idle(0); idle(1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
